// File: rtl/aud_ctrl_pkg.sv
// Shared types and constants for the audio recorder/player mode controller.
package aud_ctrl_pkg;

    localparam int unsigned AUD_ADDR_W = 20;
    localparam logic [AUD_ADDR_W-1:0] AUD_MAX_ADDR = 20'hFFFFF;

    localparam int unsigned KEY_START = 0;
    localparam int unsigned KEY_STOP  = 1;
    localparam int unsigned KEY_PAUSE = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_I2C        = 3'd1,
        ST_READY      = 3'd2,
        ST_RECD       = 3'd3,
        ST_RECD_PAUSE = 3'd4,
        ST_PLAY       = 3'd5,
        ST_PLAY_PAUSE = 3'd6
    } state_t;

endpackage

// File: rtl/key_edge_det.sv
// Rising-edge detector for a vector of synchronous key levels.
// The history register resets to all-ones so a key held through reset never fires.
module key_edge_det #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key,
    output logic [N-1:0] rise
);

    logic [N-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '1;
        else        prev <= key;
    end

    assign rise = key & ~prev;

endmodule

// File: rtl/aud_mode_ctrl.sv
// Top-level sequencer: I2C bring-up, record/play mode FSM, SRAM ownership
// and one-cycle control pulses to the recorder and DSP.
module aud_mode_ctrl
    import aud_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_W   = AUD_ADDR_W,
    parameter logic [ADDR_W-1:0]     MAX_ADDR = AUD_MAX_ADDR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_0,
    input  logic              i_key_1,
    input  logic              i_key_2,
    input  logic              i_mode_play,
    input  logic              i_i2c_finished,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_i2c_start,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic              o_sram_rec_sel,
    output logic [ADDR_W-1:0] o_rec_end,
    output logic [2:0]        o_state
);

    logic [2:0] key_rise;
    logic       ev_start, ev_pause, ev_stop, any_edge;

    key_edge_det #(.N(3)) u_key_edge (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .key   ({i_key_2, i_key_1, i_key_0}),
        .rise  (key_rise)
    );

    // Priority stop > pause > start; losers are dropped even if the winner is ignored.
    assign ev_stop  = key_rise[KEY_STOP];
    assign ev_pause = key_rise[KEY_PAUSE] & ~ev_stop;
    assign ev_start = key_rise[KEY_START] & ~ev_stop & ~key_rise[KEY_PAUSE];
    assign any_edge = |key_rise;

    state_t            state, state_nx;
    logic              rec_start_nx, rec_pause_nx, rec_stop_nx;
    logic              play_start_nx, play_pause_nx, play_stop_nx;
    logic [ADDR_W-1:0] rec_end_nx;

    always_comb begin
        state_nx      = state;
        rec_start_nx  = 1'b0;
        rec_pause_nx  = 1'b0;
        rec_stop_nx   = 1'b0;
        play_start_nx = 1'b0;
        play_pause_nx = 1'b0;
        play_stop_nx  = 1'b0;
        rec_end_nx    = o_rec_end;
        case (state)
            ST_IDLE: state_nx = ST_I2C;
            ST_I2C:  if (i_i2c_finished) state_nx = ST_READY;
            ST_READY: begin
                if (ev_start && !i_mode_play) begin
                    state_nx     = ST_RECD;
                    rec_start_nx = 1'b1;
                end else if (ev_start && o_rec_end != '0) begin
                    state_nx      = ST_PLAY;
                    play_start_nx = 1'b1;
                end
            end
            ST_RECD: begin
                if (ev_stop || (!any_edge && i_rec_addr == MAX_ADDR)) begin
                    state_nx    = ST_READY;
                    rec_stop_nx = 1'b1;
                    rec_end_nx  = i_rec_addr;
                end else if (ev_pause) begin
                    state_nx     = ST_RECD_PAUSE;
                    rec_pause_nx = 1'b1;
                end
            end
            ST_RECD_PAUSE: begin
                if (ev_stop) begin
                    state_nx    = ST_READY;
                    rec_stop_nx = 1'b1;
                    rec_end_nx  = i_rec_addr;
                end else if (ev_start) begin
                    state_nx     = ST_RECD;
                    rec_start_nx = 1'b1;
                end
            end
            ST_PLAY: begin
                if (ev_stop || i_play_addr >= o_rec_end) begin
                    state_nx     = ST_READY;
                    play_stop_nx = 1'b1;
                end else if (ev_pause) begin
                    state_nx      = ST_PLAY_PAUSE;
                    play_pause_nx = 1'b1;
                end
            end
            ST_PLAY_PAUSE: begin
                if (ev_stop) begin
                    state_nx     = ST_READY;
                    play_stop_nx = 1'b1;
                end else if (ev_start) begin
                    state_nx      = ST_PLAY;
                    play_start_nx = 1'b1;
                end
            end
            default: state_nx = ST_READY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            o_i2c_start    <= 1'b0;
            o_rec_start    <= 1'b0;
            o_rec_pause    <= 1'b0;
            o_rec_stop     <= 1'b0;
            o_play_start   <= 1'b0;
            o_play_pause   <= 1'b0;
            o_play_stop    <= 1'b0;
            o_sram_rec_sel <= 1'b0;
            o_rec_end      <= '0;
        end else begin
            state          <= state_nx;
            o_i2c_start    <= (state_nx == ST_I2C);
            o_rec_start    <= rec_start_nx;
            o_rec_pause    <= rec_pause_nx;
            o_rec_stop     <= rec_stop_nx;
            o_play_start   <= play_start_nx;
            o_play_pause   <= play_pause_nx;
            o_play_stop    <= play_stop_nx;
            o_sram_rec_sel <= (state_nx == ST_RECD) || (state_nx == ST_RECD_PAUSE);
            o_rec_end      <= rec_end_nx;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Directed and randomized checks of aud_mode_ctrl against a behavioural model.
module tb_aud_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_0 = 1'b0, key_1 = 1'b0, key_2 = 1'b0;
    logic        mode_play = 1'b0;
    logic        i2c_fin = 1'b0;
    logic [19:0] rec_addr = '0;
    logic [19:0] play_addr = '0;

    logic        i2c_start, rec_start, rec_pause, rec_stop;
    logic        play_start, play_pause, play_stop, sram_rec_sel;
    logic [19:0] rec_end;
    logic [2:0]  state;

    aud_mode_ctrl #(.ADDR_W(20), .MAX_ADDR(20'hFFFFF)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_key_0        (key_0),
        .i_key_1        (key_1),
        .i_key_2        (key_2),
        .i_mode_play    (mode_play),
        .i_i2c_finished (i2c_fin),
        .i_rec_addr     (rec_addr),
        .i_play_addr    (play_addr),
        .o_i2c_start    (i2c_start),
        .o_rec_start    (rec_start),
        .o_rec_pause    (rec_pause),
        .o_rec_stop     (rec_stop),
        .o_play_start   (play_start),
        .o_play_pause   (play_pause),
        .o_play_stop    (play_stop),
        .o_sram_rec_sel (sram_rec_sel),
        .o_rec_end      (rec_end),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: mode names as ints, keys as an abstract winner event.
    int        m_state;
    bit [2:0]  m_prev;
    bit [19:0] m_end;
    bit        m_rs, m_rp, m_rst, m_ps, m_pp, m_pst;

    task automatic model_reset();
        m_state = 0; m_prev = 3'b111; m_end = '0;
        {m_rs, m_rp, m_rst, m_ps, m_pp, m_pst} = '0;
    endtask

    task automatic model_step();
        bit [2:0] k, e;
        int win;  // 0 none, 1 start, 2 pause, 3 stop
        k = {key_2, key_1, key_0};
        e = k & ~m_prev;
        m_prev = k;
        win = e[1] ? 3 : (e[2] ? 2 : (e[0] ? 1 : 0));
        {m_rs, m_rp, m_rst, m_ps, m_pp, m_pst} = '0;
        case (m_state)
            0: m_state = 1;
            1: if (i2c_fin) m_state = 2;
            2: if (win == 1) begin
                   if (!mode_play)      begin m_state = 3; m_rs = 1; end
                   else if (m_end != 0) begin m_state = 5; m_ps = 1; end
               end
            3: if (win == 3 || (e == 0 && rec_addr == 20'hFFFFF)) begin
                   m_state = 2; m_rst = 1; m_end = rec_addr;
               end else if (win == 2) begin m_state = 4; m_rp = 1; end
            4: if (win == 3) begin m_state = 2; m_rst = 1; m_end = rec_addr; end
               else if (win == 1) begin m_state = 3; m_rs = 1; end
            5: if (win == 3 || play_addr >= m_end) begin m_state = 2; m_pst = 1; end
               else if (win == 2) begin m_state = 6; m_pp = 1; end
            6: if (win == 3) begin m_state = 2; m_pst = 1; end
               else if (win == 1) begin m_state = 5; m_ps = 1; end
            default: m_state = 2;
        endcase
    endtask

    task automatic check_outputs();
        check("state",      {29'd0, state}, m_state);
        check("i2c_start",  {31'd0, i2c_start}, {31'd0, m_state == 1});
        check("rec_start",  {31'd0, rec_start}, {31'd0, m_rs});
        check("rec_pause",  {31'd0, rec_pause}, {31'd0, m_rp});
        check("rec_stop",   {31'd0, rec_stop}, {31'd0, m_rst});
        check("play_start", {31'd0, play_start}, {31'd0, m_ps});
        check("play_pause", {31'd0, play_pause}, {31'd0, m_pp});
        check("play_stop",  {31'd0, play_stop}, {31'd0, m_pst});
        check("sram_sel",   {31'd0, sram_rec_sel}, {31'd0, (m_state == 3 || m_state == 4)});
        check("rec_end",    {12'd0, rec_end}, {12'd0, m_end});
    endtask

    task automatic tick(input bit [2:0] keys, input bit mode, input bit fin,
                        input bit [19:0] ra, input bit [19:0] pa);
        @(negedge clk);
        {key_2, key_1, key_0} = keys;
        mode_play = mode; i2c_fin = fin; rec_addr = ra; play_addr = pa;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input bit [2:0] keys);
        @(negedge clk);
        rst_n = 1'b0;
        {key_2, key_1, key_0} = keys;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // IDLE -> I2C -> (wait) -> READY
    task automatic bring_up(input bit [2:0] keys);
        repeat (10) tick(keys, 1'b0, 1'b0, '0, '0);
        tick(keys, 1'b0, 1'b1, '0, '0);
    endtask

    localparam bit [2:0] K_NONE = 3'b000, K_START = 3'b001, K_STOP = 3'b010, K_PAUSE = 3'b100;

    initial begin
        bit [19:0] pa;
        // Bring-up with i2c_finished after 10 cycles
        do_reset(K_NONE);
        bring_up(K_NONE);
        check("ready_after_i2c", {29'd0, state}, 32'd2);

        // Record then stop at 0x400
        tick(K_START, 1'b0, 1'b1, 20'h00100, '0);
        check("rec_sel_on", {31'd0, sram_rec_sel}, 32'd1);
        tick(K_START, 1'b0, 1'b1, 20'h00200, '0);
        tick(K_NONE,  1'b0, 1'b1, 20'h00400, '0);
        tick(K_STOP,  1'b0, 1'b1, 20'h00400, '0);
        check("rec_end_400", {12'd0, rec_end}, 32'h400);
        tick(K_NONE,  1'b0, 1'b1, 20'h00400, '0);

        // Play, ramp address to auto-stop at rec_end
        tick(K_START, 1'b1, 1'b1, '0, 20'h003FC);
        for (int unsigned i = 1; i <= 5; i++)
            tick(K_NONE, 1'b1, 1'b1, '0, 20'h003FC + 20'(i));
        check("play_autostop_ready", {29'd0, state}, 32'd2);

        // Fresh reset forgets the recording: play start ignored
        do_reset(K_NONE);
        bring_up(K_NONE);
        tick(K_START, 1'b1, 1'b1, '0, '0);
        check("play_no_rec", {29'd0, state}, 32'd2);
        tick(K_NONE, 1'b1, 1'b1, '0, '0);

        // Pause, then simultaneous start+stop: stop wins
        tick(K_START, 1'b0, 1'b1, 20'h00010, '0);
        tick(K_NONE,  1'b0, 1'b1, 20'h00020, '0);
        tick(K_PAUSE, 1'b0, 1'b1, 20'h00030, '0);
        check("paused", {29'd0, state}, 32'd4);
        tick(K_NONE,  1'b0, 1'b1, 20'h00030, '0);
        tick(K_START | K_STOP, 1'b0, 1'b1, 20'h00030, '0);
        check("stop_wins", {31'd0, rec_start}, 32'd0);

        // Keys held through reset release never fire
        do_reset(3'b111);
        bring_up(3'b111);
        repeat (3) tick(3'b111, 1'b0, 1'b1, '0, '0);
        tick(K_NONE, 1'b0, 1'b1, '0, '0);

        // Auto-stop recording at MAX_ADDR
        tick(K_START, 1'b0, 1'b1, 20'h00005, '0);
        tick(K_NONE,  1'b0, 1'b1, 20'hFFFFF, '0);
        check("rec_end_max", {12'd0, rec_end}, 32'hFFFFF);

        // Async reset mid-PLAY
        tick(K_START, 1'b1, 1'b1, '0, '0);
        tick(K_NONE,  1'b1, 1'b1, '0, 20'h00001);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("async_rst_state", {29'd0, state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model
        do_reset(K_NONE);
        bring_up(K_NONE);
        pa = '0;
        for (int unsigned n = 0; n < 3000; n++) begin
            bit [2:0]  keys;
            bit [19:0] ra;
            keys = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            ra = ($urandom_range(0, 31) == 0) ? 20'hFFFFF : 20'($urandom_range(0, 20'h00FFF));
            pa = (m_state == 5 || m_state == 6) ? pa + 20'($urandom_range(0, 3)) : '0;
            if (n % 700 == 699) begin
                do_reset(K_NONE);
                bring_up(K_NONE);
            end else begin
                tick(keys, ($urandom_range(0, 1) == 1), 1'b1, ra, pa);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aud_mode_ctrl.md
# aud_mode_ctrl

Top-level sequencer for the audio recorder/player. It starts WM8731 I2C initialisation and arbitrates the single SRAM between the recorder (write) and the DSP/player (read). It converts debounced key levels into one-cycle start/pause/stop pulses for each side and tracks the length of the last recording so playback auto-stops at its end.

## Interface
- ADDR_W, 20, SRAM word-address width
- MAX_ADDR, 20'hFFFFF, last writable address; reaching it auto-stops recording
- i_clk  in  1  system clock; all logic on posedge
- i_rst_n  in  1  asynchronous, active-low reset
- i_key_0  in  1  start key, debounced level, already synchronous to i_clk
- i_key_1  in  1  stop key, same
- i_key_2  in  1  pause key, same
- i_mode_play  in  1  switch: 0 = record, 1 = play; sampled only on start from READY
- i_i2c_finished  in  1  level from I2C initializer
- i_rec_addr  in  ADDR_W  recorder's current write address
- i_play_addr  in  ADDR_W  DSP's current read address
- o_i2c_start  out  1  high while in I2C state
- o_rec_start / o_rec_pause / o_rec_stop  out  1 each  one-cycle pulses to recorder
- o_play_start / o_play_pause / o_play_stop  out  1 each  one-cycle pulses to DSP
- o_sram_rec_sel  out  1  1 = recorder owns SRAM (WE_N low, DQ driven); 0 = read path
- o_rec_end  out  ADDR_W  address latched at end of last recording
- o_state  out  3  current state code, for debug/LED

## Operation
- States: IDLE(0), I2C(1), READY(2), RECD(3), RECD_PAUSE(4), PLAY(5), PLAY_PAUSE(6).
- Key edge: edge = key & ~key_prev per key. key_prev resets to 1, so a key held through reset never fires.
- Simultaneous edges: stop > pause > start. Only the winner acts; the others are dropped.
- IDLE -> I2C unconditionally on the next clock.
- I2C -> READY when i_i2c_finished = 1. Keys are ignored in IDLE and I2C.
- READY, start edge:
  - i_mode_play = 0 -> RECD, pulse o_rec_start.
  - i_mode_play = 1 and o_rec_end != 0 -> PLAY, pulse o_play_start.
  - i_mode_play = 1 and o_rec_end = 0 -> stay in READY, no pulse.
- READY: pause and stop edges are ignored.
- RECD:
  - stop edge -> READY, pulse o_rec_stop, o_rec_end <= i_rec_addr.
  - pause edge -> RECD_PAUSE, pulse o_rec_pause.
  - i_rec_addr == MAX_ADDR with no key edge -> auto-stop, identical to a stop edge.
- RECD_PAUSE:
  - start edge -> RECD, pulse o_rec_start.
  - stop edge -> READY, pulse o_rec_stop, latch o_rec_end.
  - No auto-stop in this state.
- PLAY:
  - stop edge -> READY, pulse o_play_stop.
  - pause edge -> PLAY_PAUSE, pulse o_play_pause.
  - i_play_addr >= o_rec_end (unsigned) -> auto-stop, identical to a stop edge.
- PLAY_PAUSE:
  - start edge -> PLAY, pulse o_play_start.
  - stop edge -> READY, pulse o_play_stop.
- i_mode_play changes outside READY are ignored.
- o_sram_rec_sel = 1 exactly in RECD and RECD_PAUSE. It is registered together with the state.
- Illegal state code -> READY on the next clock, no pulses.

## Timing
- Reset values: state IDLE, o_state 0, all pulse outputs 0, o_i2c_start 0, o_sram_rec_sel 0, o_rec_end 0, key_prev 3'b111.
- Reset mid-operation: all outputs return to reset values immediately. o_rec_end is cleared, so the recording is forgotten.
- Key latency: state, pulse and o_sram_rec_sel registers update on the first rising edge where key = 1 and key_prev = 0. The pulse is high for exactly that one cycle.
- Auto-stop latency: the condition is sampled at edge k; state, pulse and o_rec_end update at edge k.
- o_i2c_start rises at the edge entering I2C and falls at the edge leaving it.
- o_sram_rec_sel changes on the same edge as o_rec_start leaving READY and as o_rec_stop entering READY. The downstream SRAM mux sees no gap cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package aud_ctrl_pkg holds:
  - the state enum (3-bit, codes above);
  - ADDR_W and MAX_ADDR defaults;
  - the key-index constants KEY_START = 0, KEY_STOP = 1, KEY_PAUSE = 2.
- Sub-module key_edge_det: N-bit vector rising-edge detector with prev register reset to all-ones. Instantiated once with N = 3.
- Body:
  - one next-state/pulse always_comb;
  - one always_ff with async reset for state, pulses, o_sram_rec_sel and o_rec_end.

## Test plan
- Reset, then i_i2c_finished = 1 after 10 cycles -> o_state 0 -> 1 -> 2. o_i2c_start is high only in state 1. No pulses.
- From READY, mode = 0:
  - start -> o_rec_start pulse, o_sram_rec_sel = 1.
  - i_rec_addr = 20'h00400, then stop -> o_rec_stop pulse, o_rec_end = 20'h00400, o_sram_rec_sel = 0.
- mode = 1, start -> o_play_start. Ramp i_play_addr; at 20'h00400 -> o_play_stop pulse on that edge, state READY.
- Fresh reset, mode = 1, start -> stays READY, no pulse, because o_rec_end = 0.
- RECD, pause -> state 4. Start and stop asserted on the same edge -> only o_rec_stop, state READY.
- Keys held high across reset release -> no pulse. RECD with i_rec_addr = 20'hFFFFF -> auto o_rec_stop, o_rec_end = 20'hFFFFF. Async reset mid-PLAY -> all outputs reset immediately.
